// File: rtl/rwt_tx_pkg.sv
// ----------------------------------------------------------------------------
// rwt_tx_pkg
//   Shared definitions for the timed TX burst controller:
//     - tx_state_e        : burst controller state encoding
//     - TAG_TYPE_TIME_DEF : default tag type that carries a 64-bit start time
//     - CNT_W             : width of the status counters
//     - sat_inc()         : saturating counter update with priority clear
// ----------------------------------------------------------------------------
package rwt_tx_pkg;

    localparam int unsigned CNT_W             = 16;
    localparam logic [6:0]  TAG_TYPE_TIME_DEF = 7'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_TIME,
        ST_STREAM,
        ST_DROP
    } tx_state_e;

    // Clear wins over a coincident increment; increments stop at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             clr
    );
        if (clr) begin
            return '0;
        end
        if (inc && (cnt != '1)) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rwt_axis_pipe_reg.sv
// ----------------------------------------------------------------------------
// rwt_axis_pipe_reg
//   Single register stage for a valid/ready stream. Full throughput: the
//   stage accepts a new beat whenever it is empty or its content is being
//   taken in the same cycle.
// Ports:
//   clk, aresetn          clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_data [WIDTH-1:0]   upstream payload
//   out_valid/out_ready   downstream handshake
//   out_data [WIDTH-1:0]  registered payload (held while out_valid && !out_ready)
// ----------------------------------------------------------------------------
module rwt_axis_pipe_reg #(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (in_ready) begin
                out_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/rwt_tx_burst_ctrl.sv
// ----------------------------------------------------------------------------
// rwt_tx_burst_ctrl
//   Admits tagged sample bursts into the DAC stream. A time tag holds the
//   burst until time_now reaches the tagged start time; untagged bursts go
//   out immediately. Tag beats are always consumed and never forwarded.
// Ports:
//   clk, aresetn                  user clock, asynchronous active-low reset
//   enable                        admits new bursts (never truncates one)
//   time_now [63:0]               current sample time, unsigned
//   clear_counts                  single-cycle clear of the status counters
//   s_axi_*                       tagged input stream
//   m_axi_*                       registered sample output stream
//   busy                          controller not idle
//   late_count, burst_count       saturating status counters
// Configuration:
//   RWT_TX_BURST_LATE_DROP_EN     defined: late bursts are consumed and
//                                 dropped; undefined: late bursts are sent
//                                 immediately.
// ----------------------------------------------------------------------------
module rwt_tx_burst_ctrl
    import rwt_tx_pkg::*;
#(
    parameter logic [6:0] TAG_TYPE_TIME = TAG_TYPE_TIME_DEF
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             enable,
    input  logic [63:0]      time_now,
    input  logic             clear_counts,
    output logic             s_axi_ready,
    input  logic             s_axi_valid,
    input  logic [63:0]      s_axi_data,
    input  logic             s_axi_tag_valid,
    input  logic [6:0]       s_axi_tag_type,
    input  logic             s_axi_last,
    input  logic             m_axi_ready,
    output logic             m_axi_valid,
    output logic [63:0]      m_axi_data,
    output logic             m_axi_last,
    output logic             busy,
    output logic [CNT_W-1:0] late_count,
    output logic [CNT_W-1:0] burst_count
);

`ifdef RWT_TX_BURST_LATE_DROP_EN
    localparam tx_state_e LATE_STATE = ST_DROP;
`else
    localparam tx_state_e LATE_STATE = ST_STREAM;
`endif

    tx_state_e   state, state_nxt;
    logic [63:0] target;
    logic        target_ld;
    logic        pipe_ready;
    logic        rdy;
    logic        xfer;
    logic        is_time;
    logic        fwd;
    logic        burst_inc;
    logic        late_inc;

    // Readiness depends only on state, enable and the output stage, never
    // on s_axi_valid, so it is kept apart from the next-state logic.
    always_comb begin
        rdy = 1'b0;
        case (state)
            ST_IDLE:   rdy = enable && pipe_ready;
            ST_STREAM: rdy = pipe_ready;
            ST_DROP:   rdy = 1'b1;
            default:   rdy = 1'b0;
        endcase
    end

    assign s_axi_ready = aresetn && rdy;
    assign xfer        = s_axi_valid && s_axi_ready;
    assign is_time     = s_axi_tag_valid && (s_axi_tag_type == TAG_TYPE_TIME);
    assign busy        = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        burst_inc = 1'b0;
        late_inc  = 1'b0;
        target_ld = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    if (!s_axi_tag_valid) begin
                        fwd = 1'b1;
                        if (s_axi_last) begin
                            burst_inc = 1'b1;
                        end else begin
                            state_nxt = ST_STREAM;
                        end
                    end else if (is_time) begin
                        target_ld = 1'b1;
                        // Lateness is judged on the incoming tag itself,
                        // target only becomes valid next cycle.
                        if (time_now > s_axi_data) begin
                            late_inc  = 1'b1;
                            state_nxt = LATE_STATE;
                        end else begin
                            state_nxt = ST_WAIT_TIME;
                        end
                    end
                end
            end
            ST_WAIT_TIME: begin
                if (time_now >= target) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer && !s_axi_tag_valid) begin
                    fwd = 1'b1;
                    if (s_axi_last) begin
                        burst_inc = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (xfer && !s_axi_tag_valid && s_axi_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            target      <= '0;
            late_count  <= '0;
            burst_count <= '0;
        end else begin
            if (target_ld) begin
                target <= s_axi_data;
            end
            late_count  <= sat_inc(late_count, late_inc, clear_counts);
            burst_count <= sat_inc(burst_count, burst_inc, clear_counts);
        end
    end

    rwt_axis_pipe_reg #(
        .WIDTH (65)
    ) u_pipe (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_valid  (fwd),
        .in_ready  (pipe_ready),
        .in_data   ({s_axi_last, s_axi_data}),
        .out_valid (m_axi_valid),
        .out_data  ({m_axi_last, m_axi_data}),
        .out_ready (m_axi_ready)
    );

endmodule

// File: tb/tb_rwt_tx_burst_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rwt_tx_burst_ctrl
//   Directed bench for rwt_tx_burst_ctrl: reset, untimed, timed, late,
//   backpressure with enable drop, reset while waiting, counter saturation.
// ----------------------------------------------------------------------------
module tb_rwt_tx_burst_ctrl;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [63:0] time_now;
    logic        clear_counts;
    logic        s_axi_ready;
    logic        s_axi_valid;
    logic [63:0] s_axi_data;
    logic        s_axi_tag_valid;
    logic [6:0]  s_axi_tag_type;
    logic        s_axi_last;
    logic        m_axi_ready;
    logic        m_axi_valid;
    logic [63:0] m_axi_data;
    logic        m_axi_last;
    logic        busy;
    logic [15:0] late_count;
    logic [15:0] burst_count;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int unsigned t0;
    logic        mon_en = 1'b1;

    logic [63:0] od_q[$];
    logic        ol_q[$];
    int unsigned oc_q[$];

    rwt_tx_burst_ctrl #(
        .TAG_TYPE_TIME (7'h01)
    ) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .enable          (enable),
        .time_now        (time_now),
        .clear_counts    (clear_counts),
        .s_axi_ready     (s_axi_ready),
        .s_axi_valid     (s_axi_valid),
        .s_axi_data      (s_axi_data),
        .s_axi_tag_valid (s_axi_tag_valid),
        .s_axi_tag_type  (s_axi_tag_type),
        .s_axi_last      (s_axi_last),
        .m_axi_ready     (m_axi_ready),
        .m_axi_valid     (m_axi_valid),
        .m_axi_data      (m_axi_data),
        .m_axi_last      (m_axi_last),
        .busy            (busy),
        .late_count      (late_count),
        .burst_count     (burst_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after posedge, so negedge sees the handshake that
    // the next posedge will complete.
    always @(negedge clk) begin
        if (mon_en && m_axi_valid && m_axi_ready) begin
            od_q.push_back(m_axi_data);
            ol_q.push_back(m_axi_last);
            oc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic tv, input logic [6:0] tt, input logic lst);
        logic ok;
        ok              = 1'b0;
        s_axi_valid     = 1'b1;
        s_axi_data      = d;
        s_axi_tag_valid = tv;
        s_axi_tag_type  = tt;
        s_axi_last      = lst;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (s_axi_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_axi_valid     = 1'b0;
        s_axi_tag_valid = 1'b0;
        s_axi_last      = 1'b0;
        chk("send_accepted", {63'd0, ok}, 64'd1);
    endtask

    task automatic data(input logic [63:0] d, input logic lst);
        send(d, 1'b0, 7'h00, lst);
    endtask

    task automatic clear_q();
        od_q.delete();
        ol_q.delete();
        oc_q.delete();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn         = 1'b0;
        enable          = 1'b1;
        time_now        = '0;
        clear_counts    = 1'b0;
        s_axi_valid     = 1'b0;
        s_axi_data      = '0;
        s_axi_tag_valid = 1'b0;
        s_axi_tag_type  = '0;
        s_axi_last      = 1'b0;
        m_axi_ready     = 1'b1;
        step(3);

        // Reset state
        chk("rst_s_ready", s_axi_ready, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_m_valid", m_axi_valid, 0);
        chk("rst_m_data",  m_axi_data, 0);
        chk("rst_m_last",  m_axi_last, 0);
        chk("rst_late",    late_count, 0);
        chk("rst_burst",   burst_count, 0);

        enable  = 1'b0;
        aresetn = 1'b1;
        step(2);
        chk("idle_blocked", s_axi_ready, 0);
        enable = 1'b1;
        #1;
        chk("idle_open", s_axi_ready, 1);

        // Untimed burst, preceded by a non-time tag carrying last
        clear_q();
        send(64'h55, 1'b1, 7'h22, 1'b1);
        chk("tag_busy", busy, 0);
        t0 = cyc;
        data(64'hA0, 1'b0);
        chk("untimed_busy", busy, 1);
        data(64'hA1, 1'b0);
        data(64'hA2, 1'b0);
        data(64'hA3, 1'b1);
        step(2);
        chk("untimed_cnt", od_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < od_q.size()) begin
                chk("untimed_data", od_q[i], 64'hA0 + i);
                chk("untimed_last", ol_q[i], (i == 3) ? 1 : 0);
                chk("untimed_cyc",  oc_q[i], t0 + 1 + i);
            end
        end
        chk("untimed_busy_end", busy, 0);
        chk("untimed_burst",    burst_count, 1);

        // Timed burst: tag 1000 at 900
        clear_q();
        time_now = 64'd900;
        send(64'd1000, 1'b1, 7'h01, 1'b0);
        chk("timed_busy", busy, 1);
        for (int k = 0; k < 10; k++) begin
            time_now = 64'd900 + 64'(k * 10);
            step(1);
            chk("wait_ready", s_axi_ready, 0);
        end
        time_now = 64'd999;
        step(1);
        chk("wait_ready_999", s_axi_ready, 0);
        chk("wait_busy_999",  busy, 1);
        chk("wait_noout",     od_q.size(), 0);
        time_now = 64'd1000;
        t0 = cyc;
        data(64'hB0, 1'b0);
        chk("timed_busy_strm", busy, 1);
        data(64'hB1, 1'b0);
        data(64'hB2, 1'b1);
        step(2);
        chk("timed_cnt", od_q.size(), 3);
        if (od_q.size() > 0) begin
            chk("timed_first_cyc",  oc_q[0], t0 + 2);
            chk("timed_first_data", od_q[0], 64'hB0);
        end
        if (od_q.size() > 2) chk("timed_last_data", od_q[2], 64'hB2);
        chk("timed_busy_end", busy, 0);
        chk("timed_burst",    burst_count, 2);

        // Late burst: tag 500 at 600; stray time tag inside the burst
        clear_q();
        time_now = 64'd600;
        send(64'd500, 1'b1, 7'h01, 1'b0);
        chk("late_count", late_count, 1);
        chk("late_busy",  busy, 1);
        send(64'd0, 1'b1, 7'h01, 1'b0);
        chk("late_stray_busy", busy, 1);
        data(64'hC0, 1'b0);
        data(64'hC1, 1'b0);
        data(64'hC2, 1'b1);
        step(2);
`ifdef RWT_TX_BURST_LATE_DROP_EN
        chk("late_cnt_out", od_q.size(), 0);
        chk("late_burst",   burst_count, 2);
`else
        chk("late_cnt_out", od_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < od_q.size()) chk("late_data", od_q[i], 64'hC0 + i);
        end
        chk("late_burst", burst_count, 3);
`endif
        chk("late_busy_end", busy, 0);
        chk("late_count_end", late_count, 1);

        // Backpressure on an 8-beat burst; enable drops after the first beat
        clear_q();
        time_now = 64'd0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    data(64'hD0 + 64'(i), (i == 7));
                    if (i == 0) enable = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    m_axi_ready = (k % 3 != 0);
                    @(posedge clk);
                    #1;
                end
                m_axi_ready = 1'b1;
            end
        join
        step(2);
        chk("bp_cnt", od_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < od_q.size()) begin
                chk("bp_data", od_q[i], 64'hD0 + i);
                chk("bp_last", ol_q[i], (i == 7) ? 1 : 0);
            end
        end
        chk("bp_busy_end",     busy, 0);
        chk("bp_idle_blocked", s_axi_ready, 0);
`ifdef RWT_TX_BURST_LATE_DROP_EN
        chk("bp_burst", burst_count, 3);
`else
        chk("bp_burst", burst_count, 4);
`endif
        enable = 1'b1;

        // Reset while in WAIT_TIME
        time_now = 64'd100;
        send(64'd5000, 1'b1, 7'h01, 1'b0);
        chk("wr_busy",        busy, 1);
        chk("wr_m_data_pre",  m_axi_data, 64'hD7);
        step(1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("wr_busy_rst",    busy, 0);
        chk("wr_ready_rst",   s_axi_ready, 0);
        chk("wr_m_valid_rst", m_axi_valid, 0);
        chk("wr_m_data_rst",  m_axi_data, 0);
        chk("wr_m_last_rst",  m_axi_last, 0);
        chk("wr_late_rst",    late_count, 0);
        chk("wr_burst_rst",   burst_count, 0);
        step(1);
        aresetn = 1'b1;
        step(1);
        clear_q();
        t0 = cyc;
        data(64'hE0, 1'b1);
        step(1);
        chk("wr_post_cnt", od_q.size(), 1);
        if (od_q.size() > 0) begin
            chk("wr_post_data", od_q[0], 64'hE0);
            chk("wr_post_cyc",  oc_q[0], t0 + 1);
        end
        chk("wr_post_burst", burst_count, 1);

        // Saturation and clear
        mon_en = 1'b0;
        clear_counts = 1'b1;
        step(1);
        clear_counts = 1'b0;
        chk("clr_burst", burst_count, 0);
        for (int i = 0; i < 65535; i++) data(64'(i), 1'b1);
        chk("sat_ffff", burst_count, 16'hFFFF);
        data(64'h1, 1'b1);
        data(64'h2, 1'b1);
        chk("sat_hold", burst_count, 16'hFFFF);
        clear_counts = 1'b1;
        data(64'h3, 1'b1);
        clear_counts = 1'b0;
        chk("clr_coincident", burst_count, 0);
        chk("sat_late", late_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
